// File: rtl/legv8_control_unit.sv
// Multicycle LEGv8 sequencer: fetch/decode/execute over the tri-state datapath,
// emitting the 40-bit ControlWord and the decoded immediate `constant`.
module legv8_control_unit #(
   parameter int unsigned CW_WIDTH   = 40,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           IR_out,
   input  logic [4:0]            status,
   input  logic                  mem_ready,
   output logic [CW_WIDTH-1:0]   ControlWord,
   output logic [DATA_WIDTH-1:0] constant,
   output logic [2:0]            state,
   output logic                  halted
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'b000,
      ST_DECODE = 3'b001,
      ST_EXEC   = 3'b010,
      ST_MEM    = 3'b011,
      ST_BRANCH = 3'b100,
      ST_RST    = 3'b101,
      ST_HALT   = 3'b111
   } state_e;

   typedef struct packed {
      logic [5:0] rsvd;
      logic       addr_pc;
      logic [1:0] dsel;
      logic [1:0] ps;
      logic       pc_to_a;
      logic       bsel;
      logic       ir_load;
      logic       status_load;
      logic [4:0] fs;
      logic       c0;
      logic [1:0] msize;
      logic       mem_write;
      logic       reg_write;
      logic [4:0] da;
      logic [4:0] sa;
      logic [4:0] sb;
   } cw_t;

   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
   localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [5:0]  OPC_B    = 6'b000101;
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
   localparam logic [7:0]  OPC_CBNZ = 8'b10110101;

   localparam logic [4:0]  FS_AND = 5'b00000;
   localparam logic [4:0]  FS_ORR = 5'b00100;
   localparam logic [4:0]  FS_ADD = 5'b01000;
   localparam logic [4:0]  FS_SUB = 5'b01001;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] constant_q, constant_d;
   cw_t                   cw;

   logic [10:0] opc11;
   logic [9:0]  opc10;
   logic        is_r, is_i, is_ld, is_st, is_b, is_cbz, is_cbnz, is_cb, is_sub;
   logic [4:0]  fs_op;
   logic [4:0]  rd, rn, rm;
   logic        taken;
   logic        unused_status;

   assign opc11   = IR_out[31:21];
   assign opc10   = IR_out[31:22];
   assign is_r    = opc11 inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR};
   assign is_i    = opc10 inside {OPC_ADDI, OPC_SUBI};
   assign is_ld   = (opc11 == OPC_LDUR);
   assign is_st   = (opc11 == OPC_STUR);
   assign is_b    = (IR_out[31:26] == OPC_B);
   assign is_cbz  = (IR_out[31:24] == OPC_CBZ);
   assign is_cbnz = (IR_out[31:24] == OPC_CBNZ);
   assign is_cb   = is_cbz | is_cbnz;
   assign is_sub  = (opc11 == OPC_SUB) | (opc10 == OPC_SUBI);
   assign fs_op   = (opc11 == OPC_AND) ? FS_AND :
                    (opc11 == OPC_ORR) ? FS_ORR :
                    is_sub             ? FS_SUB : FS_ADD;
   assign rd      = IR_out[4:0];
   assign rn      = IR_out[9:5];
   assign rm      = IR_out[20:16];
   assign taken   = is_b | (is_cbz & status[0]) | (is_cbnz & ~status[0]);
   assign unused_status = ^status[4:1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_RST;
         constant_q <= '0;
      end else begin
         state_q    <= state_d;
         constant_q <= constant_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      constant_d = constant_q;
      cw         = '0;
      case (state_q)
         ST_RST: state_d = ST_FETCH;
         ST_FETCH: begin
            cw.addr_pc = 1'b1;
            cw.dsel    = 2'b11;
            cw.msize   = 2'b11;
            if (mem_ready) begin
               cw.ir_load = 1'b1;
               cw.ps      = 2'b01;
               state_d    = ST_DECODE;
            end
         end
         ST_DECODE: begin
            // Branch offsets subtract 4 to undo the PC+4 already applied in FETCH.
            if (is_i)
               constant_d = {{(DATA_WIDTH-12){1'b0}}, IR_out[21:10]};
            else if (is_ld || is_st)
               constant_d = {{(DATA_WIDTH-9){IR_out[20]}}, IR_out[20:12]};
            else if (is_b)
               constant_d = {{(DATA_WIDTH-28){IR_out[25]}}, IR_out[25:0], 2'b00} - DATA_WIDTH'(4);
            else if (is_cb)
               constant_d = {{(DATA_WIDTH-21){IR_out[23]}}, IR_out[23:5], 2'b00} - DATA_WIDTH'(4);
            if (is_r || is_i || is_cb) state_d = ST_EXEC;
            else if (is_ld || is_st)   state_d = ST_MEM;
            else if (is_b)             state_d = ST_BRANCH;
            else                       state_d = ST_HALT;
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            if (is_cb) begin
               cw.sa          = rd;
               cw.sb          = 5'd31;
               cw.fs          = FS_ADD;
               cw.status_load = 1'b1;
               state_d        = ST_BRANCH;
            end else begin
               cw.da        = rd;
               cw.sa        = rn;
               cw.sb        = is_i ? 5'd0 : rm;
               cw.bsel      = is_i;
               cw.fs        = fs_op;
               cw.c0        = is_sub;
               cw.reg_write = 1'b1;
            end
         end
         ST_MEM: begin
            cw.sa    = rn;
            cw.bsel  = 1'b1;
            cw.fs    = FS_ADD;
            cw.msize = 2'b11;
            if (is_st) begin
               cw.sb        = rd;
               cw.dsel      = 2'b01;
               cw.mem_write = 1'b1;
            end else begin
               cw.da        = rd;
               cw.dsel      = 2'b11;
               cw.reg_write = mem_ready;
            end
            if (mem_ready) state_d = ST_FETCH;
         end
         ST_BRANCH: begin
            if (taken) begin
               cw.ps   = 2'b11;
               cw.bsel = 1'b1;
            end
            state_d = ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_HALT;
      endcase
   end

   assign ControlWord = CW_WIDTH'(cw);
   assign constant    = constant_q;
   assign state       = state_q;
   assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_legv8_control_unit.sv
// Randomised bench for legv8_control_unit: an instruction-level model queues the
// expected per-cycle outputs and a negedge monitor compares them against the DUT.
module tb_legv8_control_unit;

   localparam logic [2:0] S_RST = 3'b101, S_FETCH = 3'b000, S_DEC = 3'b001,
                          S_EXEC = 3'b010, S_MEM = 3'b011, S_BR = 3'b100, S_HALT = 3'b111;

   localparam int unsigned P_SB = 0, P_SA = 5, P_DA = 10, P_RW = 15, P_MW = 16, P_MSZ = 17,
                           P_C0 = 19, P_FS = 20, P_SL = 25, P_IRL = 26, P_BSEL = 27,
                           P_PS = 29, P_DSEL = 31, P_APC = 33;

   localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_ORR = 3, OP_ADDI = 4, OP_SUBI = 5,
                  OP_LDUR = 6, OP_STUR = 7, OP_B = 8, OP_CBZ = 9, OP_CBNZ = 10, OP_BAD = 11;

   typedef struct packed {
      logic [39:0] cw;
      logic [63:0] k;
      logic [2:0]  st;
      logic        h;
   } exp_t;

   logic        clock;
   logic        reset;
   logic [31:0] IR_out;
   logic [4:0]  status;
   logic        mem_ready;
   logic [39:0] ControlWord;
   logic [63:0] constant;
   logic [2:0]  state;
   logic        halted;

   exp_t        sb_q[$];
   logic [63:0] exp_const;
   bit          mon_en;
   int          errors;
   int          checks;
   int          cyc;

   legv8_control_unit #(.CW_WIDTH(40), .DATA_WIDTH(64)) dut (
      .clock(clock), .reset(reset), .IR_out(IR_out), .status(status),
      .mem_ready(mem_ready), .ControlWord(ControlWord), .constant(constant),
      .state(state), .halted(halted)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Monitor: one expected entry per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            checks++;
            cyc++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_empty cycle %0d: no expected entry queued", cyc);
            end else begin
               e = sb_q.pop_front();
               if (ControlWord !== e.cw || constant !== e.k || state !== e.st || halted !== e.h) begin
                  errors++;
                  $display("FAIL cycle %0d (exp state %b): got cw=%h k=%h state=%b halted=%b, expected cw=%h k=%h state=%b halted=%b",
                           cyc, e.st, ControlWord, constant, state, halted, e.cw, e.k, e.st, e.h);
               end
            end
         end
      end
   end

   function automatic logic [39:0] fld(input int unsigned lsb, input int unsigned val);
      logic [39:0] v;
      v = 40'(val);
      return v << lsb;
   endfunction

   function automatic logic [4:0] rnd_status();
      return 5'($urandom);
   endfunction

   function automatic int unsigned fs_of(input int op);
      case (op)
         OP_AND:          return 0;
         OP_ORR:          return 4;
         OP_SUB, OP_SUBI: return 9;
         default:         return 8;
      endcase
   endfunction

   function automatic logic [31:0] make_ir(input int op);
      logic [31:0] r;
      r = $urandom;
      case (op)
         OP_ADD:  return {11'b10001011000, r[20:0]};
         OP_SUB:  return {11'b11001011000, r[20:0]};
         OP_AND:  return {11'b10001010000, r[20:0]};
         OP_ORR:  return {11'b10101010000, r[20:0]};
         OP_ADDI: return {10'b1001000100, r[21:0]};
         OP_SUBI: return {10'b1101000100, r[21:0]};
         OP_LDUR: return {11'b11111000010, r[20:12], 2'b00, r[9:0]};
         OP_STUR: return {11'b11111000000, r[20:12], 2'b00, r[9:0]};
         OP_B:    return {6'b000101, r[25:0]};
         OP_CBZ:  return {8'b10110100, r[23:0]};
         OP_CBNZ: return {8'b10110101, r[23:0]};
         default: return 32'h0000_0000;
      endcase
   endfunction

   task automatic drive(input logic [31:0] ir, input logic rdy, input logic [4:0] stv,
                        input logic rs, input logic [39:0] cw, input logic [2:0] st, input logic h);
      exp_t e;
      @(posedge clock);
      #1;
      IR_out    = ir;
      mem_ready = rdy;
      status    = stv;
      reset     = rs;
      if (!rs) exp_const = '0;
      e.cw = cw;
      e.k  = exp_const;
      e.st = st;
      e.h  = h;
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      drive(IR_out, 1'($urandom), rnd_status(), 1'b0, 40'd0, S_RST, 1'b0);
      drive(IR_out, 1'($urandom), rnd_status(), 1'b0, 40'd0, S_RST, 1'b0);
      drive(IR_out, 1'($urandom), rnd_status(), 1'b1, 40'd0, S_RST, 1'b0);
   endtask

   // One instruction from the model's point of view: waits of -1 mean random,
   // zflag of -1 means random Z; abort stops after the first stalled MEM cycle.
   task automatic run_instr(input int op, input logic [31:0] ir, input int fwait,
                            input int mwait, input int zflag, input bit abort);
      int          n;
      logic        rdy;
      logic [4:0]  stv;
      logic [39:0] cw;
      longint      sx;
      int unsigned rd, rn, rm, fs;
      bit          taken;
      rd = ir[4:0];
      rn = ir[9:5];
      rm = ir[20:16];
      fs = fs_of(op);

      n = 0;
      forever begin
         rdy = (fwait >= 0) ? (n >= fwait) : (n >= 5 || $urandom_range(0, 3) != 0);
         cw  = fld(P_APC, 1) | fld(P_DSEL, 3) | fld(P_MSZ, 3);
         if (rdy) cw = cw | fld(P_IRL, 1) | fld(P_PS, 1);
         drive(ir, rdy, rnd_status(), 1'b1, cw, S_FETCH, 1'b0);
         n++;
         if (rdy) break;
      end

      drive(ir, 1'($urandom), rnd_status(), 1'b1, 40'd0, S_DEC, 1'b0);
      case (op)
         OP_ADDI, OP_SUBI: exp_const = 64'(ir[21:10]);
         OP_LDUR, OP_STUR: begin sx = $signed(ir[20:12]); exp_const = sx; end
         OP_B:             begin sx = $signed(ir[25:0]);  exp_const = sx * 4 - 4; end
         OP_CBZ, OP_CBNZ:  begin sx = $signed(ir[23:5]);  exp_const = sx * 4 - 4; end
         default: ;
      endcase

      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_ORR:
            drive(ir, 1'($urandom), rnd_status(), 1'b1,
                  fld(P_DA, rd) | fld(P_SA, rn) | fld(P_SB, rm) | fld(P_FS, fs) |
                  fld(P_C0, (op == OP_SUB) ? 1 : 0) | fld(P_RW, 1), S_EXEC, 1'b0);
         OP_ADDI, OP_SUBI:
            drive(ir, 1'($urandom), rnd_status(), 1'b1,
                  fld(P_DA, rd) | fld(P_SA, rn) | fld(P_BSEL, 1) | fld(P_FS, fs) |
                  fld(P_C0, (op == OP_SUBI) ? 1 : 0) | fld(P_RW, 1), S_EXEC, 1'b0);
         OP_LDUR, OP_STUR: begin
            n = 0;
            forever begin
               if (abort && n == 1) return;
               rdy = (mwait >= 0) ? (n >= mwait) : (n >= 5 || $urandom_range(0, 2) != 0);
               if (op == OP_LDUR)
                  cw = fld(P_SA, rn) | fld(P_BSEL, 1) | fld(P_FS, 8) | fld(P_DSEL, 3) |
                       fld(P_MSZ, 3) | fld(P_DA, rd) | fld(P_RW, rdy ? 1 : 0);
               else
                  cw = fld(P_SA, rn) | fld(P_SB, rd) | fld(P_BSEL, 1) | fld(P_FS, 8) |
                       fld(P_DSEL, 1) | fld(P_MSZ, 3) | fld(P_MW, 1);
               drive(ir, rdy, rnd_status(), 1'b1, cw, S_MEM, 1'b0);
               n++;
               if (rdy) break;
            end
         end
         OP_B:
            drive(ir, 1'($urandom), rnd_status(), 1'b1, fld(P_PS, 3) | fld(P_BSEL, 1), S_BR, 1'b0);
         OP_CBZ, OP_CBNZ: begin
            drive(ir, 1'($urandom), rnd_status(), 1'b1,
                  fld(P_SA, rd) | fld(P_SB, 31) | fld(P_FS, 8) | fld(P_SL, 1), S_EXEC, 1'b0);
            stv = rnd_status();
            if (zflag >= 0) stv[0] = 1'(zflag);
            taken = (op == OP_CBZ) ? (stv[0] == 1'b1) : (stv[0] == 1'b0);
            drive(ir, 1'($urandom), stv, 1'b1, taken ? (fld(P_PS, 3) | fld(P_BSEL, 1)) : 40'd0,
                  S_BR, 1'b0);
         end
         default:
            for (int i = 0; i < 10; i++)
               drive(ir, 1'($urandom), rnd_status(), 1'b1, 40'd0, S_HALT, 1'b1);
      endcase
   endtask

   initial begin
      int op;
      reset     = 1'b0;
      IR_out    = '0;
      status    = '0;
      mem_ready = 1'b0;
      exp_const = '0;
      errors    = 0;
      checks    = 0;
      cyc       = 0;
      mon_en    = 1'b1;

      do_reset();
      run_instr(OP_ADD,  32'h8B02_0023, 0, -1, -1, 1'b0);
      run_instr(OP_LDUR, 32'hF840_83E2, 1, 3, -1, 1'b0);
      run_instr(OP_CBZ,  32'hB400_0040, 0, -1, 1, 1'b0);
      run_instr(OP_CBZ,  32'hB400_0040, 0, -1, 0, 1'b0);
      run_instr(OP_CBNZ, 32'hB500_0040, 0, -1, 0, 1'b0);
      run_instr(OP_B,    32'h17FF_FFFF, 0, -1, -1, 1'b0);
      run_instr(OP_STUR, make_ir(OP_STUR), 0, 5, -1, 1'b1);
      do_reset();

      for (int i = 0; i < 80; i++) begin
         op = $urandom_range(0, 10);
         run_instr(op, make_ir(op), -1, -1, -1, 1'b0);
      end

      run_instr(OP_BAD, 32'h0000_0000, -1, -1, -1, 1'b0);
      do_reset();
      run_instr(OP_SUBI, make_ir(OP_SUBI), -1, -1, -1, 1'b0);

      @(negedge clock);
      #1;
      mon_en = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
- Multicycle sequencer that drives the 40-bit ControlWord of the LEGv8 tri-state datapath.
- Runs fetch/decode/execute, sources the datapath `constant` from the instruction, and stalls on memory via a ready handshake.
- Supported subset: ADD, SUB, AND, ORR, ADDI, SUBI, LDUR, STUR, B, CBZ, CBNZ. Any other opcode halts the sequencer.

Parameters:
- CW_WIDTH, 40, ControlWord width.
- DATA_WIDTH, 64, constant width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- IR_out  in  32  instruction register from the datapath.
- status  in  5  latched datapath flags; [0]=Z, [1]=N, [2]=C, [3]=V, [4] unused.
- mem_ready  in  1  memory completes the access in the current cycle.
- ControlWord  out  40  datapath control word.
- constant  out  64  immediate for the datapath.
- state  out  3  current state, for debug.
- halted  out  1  sequencer is in HALT.

Behaviour:
- ControlWord fields:
  - [4:0]=SB, [9:5]=SA, [14:10]=DA, [15]=RegWrite, [16]=MemWrite, [18:17]=MemSize (11 = doubleword when memory is accessed, else 00).
  - [19]=C0, [24:20]=FS (AND 00000, ORR 00100, ADD 01000, SUB 01001 with C0=1), [25]=StatusLoad, [26]=IRLoad, [27]=Bsel (1 = constant).
  - [28]=PCtoA, [30:29]=PS (00 hold, 01 +4, 10 load, 11 PC+constant), [32:31]=DataSel (00 ALU, 01 RegB to memory, 10 PC, 11 memory), [33]=AddrFromPC, [39:34]=0.
- States: RST=101, FETCH=000, DECODE=001, EXEC=010, MEM=011, BRANCH=100, HALT=111. ControlWord is combinational from state, IR_out and mem_ready.
- Reset low: state=RST asynchronously. Then ControlWord=0, constant=0, halted=0. The first clock after reset rises moves RST to FETCH. Reset in any state aborts the operation immediately.
- FETCH:
  - Outputs AddrFromPC=1, DataSel=11, MemSize=11.
  - When mem_ready=1, also IRLoad=1 and PS=01, and the next state is DECODE. Otherwise IRLoad=0, PS=00, and the state is held.
- DECODE:
  - ControlWord=0.
  - constant is registered from IR_out:
    - ADDI/SUBI: zero-extended IR[21:10].
    - LDUR/STUR: sign-extended IR[20:12].
    - B: (SignExt(IR[25:0])<<2)-4.
    - CBZ/CBNZ: (SignExt(IR[23:5])<<2)-4.
    - The -4 compensates for the +4 applied in FETCH.
  - Next state: R/I-type → EXEC; LDUR/STUR → MEM; B → BRANCH; CBZ/CBNZ → EXEC; anything else → HALT.
- Register fields: Rd=IR[4:0], Rn=IR[9:5], Rm=IR[20:16], Rt=IR[4:0].
- EXEC, R-type: DA=Rd, SA=Rn, SB=Rm, FS per opcode, RegWrite=1, DataSel=00. Next state FETCH.
- EXEC, I-type: same as R-type, but Bsel=1 and SB=0.
- EXEC, CBZ/CBNZ: SA=Rt, SB=31, FS=ADD, StatusLoad=1, RegWrite=0. Next state BRANCH.
- MEM, LDUR:
  - SA=Rn, Bsel=1, FS=ADD, DataSel=11, MemSize=11, DA=Rt.
  - RegWrite=1 only when mem_ready=1.
- MEM, STUR:
  - SA=Rn, SB=Rt, Bsel=1, FS=ADD, DataSel=01, MemSize=11.
  - MemWrite=1 is held until mem_ready=1.
- MEM exits to FETCH on mem_ready=1 and stays otherwise.
- BRANCH:
  - Taken condition: B always; CBZ when status[0]=1; CBNZ when status[0]=0.
  - Taken: PS=11, Bsel=1. Not taken: ControlWord=0.
  - Next state FETCH.
- HALT: ControlWord=0, halted=1. Left only via reset.
- Latency with mem_ready held high: R/I-type 3 cycles; LDUR/STUR 3; B 3; CBZ/CBNZ 4. Each mem_ready=0 cycle adds 1.

Test Plan:
- Reset low mid-MEM (STUR, mem_ready=0) → ControlWord=0 and state=101 asynchronously. After release, FETCH on the next edge.
- IR_out=0x8B020023 (ADD X3,X1,X2), mem_ready=1 → EXEC word has DA=3, SA=1, SB=2, FS=01000, RegWrite=1, C0=0. Back in FETCH after 3 cycles.
- IR_out=0xF84083E2 (LDUR X2,[X31,#8]), mem_ready low for 3 MEM cycles:
  - constant=8.
  - The MEM state is held for 4 cycles with RegWrite=0 for the first 3 and RegWrite=1 on the ready cycle, then FETCH.
- IR_out=0xB4000040 (CBZ X0,#8):
  - constant=4.
  - status[0]=1 → BRANCH emits PS=11.
  - status[0]=0 → BRANCH emits ControlWord=0.
- IR_out=0x17FFFFFF (B #-4) → constant=0xFFFFFFFFFFFFFFF8; BRANCH emits PS=11, Bsel=1.
- IR_out=0x00000000 → DECODE→HALT. halted=1 and ControlWord=0 for 10 cycles; cleared by reset.
